// File: rtl/score_bcd_tracker.sv
// Binary score to 3-digit BCD via serial double-dabble, plus session high-score tracking.
// Optional high-score logic is enabled by defining SCORE_HISCORE_EN.
module score_bcd_tracker #(
  parameter int SCORE_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SCORE_W-1:0] score,
  input  logic               game_end,
  input  logic               clear_hi,
  output logic               busy,
  output logic               bcd_valid,
  output logic [3:0]         hundreds,
  output logic [3:0]         tens,
  output logic [3:0]         ones,
  output logic [SCORE_W-1:0] hi_score,
  output logic               new_record
);
  localparam int SH_W = SCORE_W + 12;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_reg;
  logic [SH_W-1:0]    shifter_reg;
  logic [SH_W-1:0]    shifter_next;
  logic [3:0]         cnt_reg;
  logic [SCORE_W-1:0] last_score_reg;
  logic               pend_reg;
  logic               chg;
  logic               fin;
  logic               start;
  logic [3:0]         nib_adj [3];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_adj
      logic [3:0] nib;
      assign nib         = shifter_reg[SCORE_W + 4*gi +: 4];
      assign nib_adj[gi] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
  endgenerate

  // Correct every BCD nibble first, then shift the whole register by one bit.
  assign shifter_next = {nib_adj[2], nib_adj[1], nib_adj[0], shifter_reg[SCORE_W-1:0]} << 1;

  assign chg   = (score != last_score_reg);
  assign start = chg | fin | pend_reg;
  assign busy  = (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      shifter_reg    <= '0;
      cnt_reg        <= '0;
      last_score_reg <= '0;
      pend_reg       <= 1'b0;
      bcd_valid      <= 1'b0;
      hundreds       <= '0;
      tens           <= '0;
      ones           <= '0;
    end else begin
      bcd_valid <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (start) begin
            shifter_reg    <= {12'b0, score};
            last_score_reg <= score;
            cnt_reg        <= 4'(SCORE_W);
            pend_reg       <= 1'b0;
            state_reg      <= SHIFT;
          end
        end
        SHIFT: begin
          if (chg | fin) pend_reg <= 1'b1;
          if (cnt_reg != 4'd0) begin
            shifter_reg <= shifter_next;
            cnt_reg     <= cnt_reg - 4'd1;
          end else begin
            hundreds  <= shifter_reg[SCORE_W+8 +: 4];
            tens      <= shifter_reg[SCORE_W+4 +: 4];
            ones      <= shifter_reg[SCORE_W   +: 4];
            bcd_valid <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          if (chg | fin) pend_reg <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef SCORE_HISCORE_EN
  logic prev_end_reg;
  logic pend_final_reg;
  logic is_final_reg;

  assign fin = game_end & ~prev_end_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_end_reg   <= 1'b0;
      pend_final_reg <= 1'b0;
      is_final_reg   <= 1'b0;
      hi_score       <= '0;
      new_record     <= 1'b0;
    end else begin
      prev_end_reg <= game_end;
      new_record   <= 1'b0;
      if (state_reg == IDLE) begin
        if (start) begin
          is_final_reg   <= fin | pend_final_reg;
          pend_final_reg <= 1'b0;
        end
      end else if (fin) begin
        pend_final_reg <= 1'b1;
      end
      if (state_reg == SHIFT && cnt_reg == 4'd0)
        new_record <= is_final_reg && (last_score_reg > hi_score);
      if (state_reg == DONE && new_record)
        hi_score <= last_score_reg;
      // Clearing takes priority over a record captured on the same edge.
      if (clear_hi)
        hi_score <= '0;
    end
  end
`else
  logic unused_inputs;

  assign fin           = 1'b0;
  assign hi_score      = '0;
  assign new_record    = 1'b0;
  assign unused_inputs = ^{game_end, clear_hi};
`endif

endmodule

// File: tb/tb_score_bcd_tracker.sv
// Self-checking bench for score_bcd_tracker: directed scenarios plus a randomized run
// checked cycle by cycle against a timeline-level reference model.
module tb_score_bcd_tracker;
  localparam int W = 8;
`ifdef SCORE_HISCORE_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] score;
  logic         game_end;
  logic         clear_hi;
  logic         busy;
  logic         bcd_valid;
  logic [3:0]   hundreds;
  logic [3:0]   tens;
  logic [3:0]   ones;
  logic [W-1:0] hi_score;
  logic         new_record;

  int checks   = 0;
  int failures = 0;

  score_bcd_tracker #(.SCORE_W(W)) dut (
    .clk(clk), .rst(rst), .score(score), .game_end(game_end), .clear_hi(clear_hi),
    .busy(busy), .bcd_valid(bcd_valid), .hundreds(hundreds), .tens(tens), .ones(ones),
    .hi_score(hi_score), .new_record(new_record)
  );

  always #5 clk = ~clk;

  // Reference model: a conversion is a timeline measured from its start edge.
  int m_age = -1;
  int m_val, m_last, m_hi, m_h, m_t, m_o;
  bit m_pend, m_pf, m_final, m_prev, m_valid, m_rec;

  task automatic model_update();
    bit fin, chg;
    if (rst) begin
      m_age = -1; m_val = 0; m_last = 0; m_hi = 0; m_h = 0; m_t = 0; m_o = 0;
      m_pend = 0; m_pf = 0; m_final = 0; m_prev = 0; m_valid = 0; m_rec = 0;
      return;
    end
    fin = HI_EN && game_end && !m_prev;
    chg = (int'(score) != m_last);
    if (m_age < 0) begin
      if (chg || fin || m_pend) begin
        m_age = 0; m_val = int'(score); m_last = int'(score);
        m_final = fin || m_pf; m_pend = 0; m_pf = 0;
      end
    end else begin
      if (chg) m_pend = 1;
      if (fin) begin m_pf = 1; m_pend = 1; end
      m_age++;
      if (m_age == W + 1) begin
        m_h = m_val / 100; m_t = (m_val / 10) % 10; m_o = m_val % 10;
        m_valid = 1;
        m_rec = HI_EN && m_final && (m_val > m_hi);
      end else if (m_age == W + 2) begin
        if (m_rec) m_hi = m_val;
        m_valid = 0; m_rec = 0; m_age = -1;
      end
    end
    if (HI_EN && clear_hi) m_hi = 0;
    m_prev = game_end;
  endtask

  function automatic logic [W+14:0] model_vec();
    return {(m_age >= 0), m_valid, 4'(m_h), 4'(m_t), 4'(m_o), W'(m_hi), m_rec};
  endfunction

  function automatic logic [W+14:0] dut_vec();
    return {busy, bcd_valid, hundreds, tens, ones, hi_score, new_record};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Drives a final score (game_end rising with the new score) and waits for its digits.
  task automatic run_final(input logic [W-1:0] v, input bit clr_on_done,
                           output bit saw_rec, output bit timed_out);
    game_end = 1'b0; tick();
    score = v; game_end = 1'b1; tick();
    timed_out = 1'b1;
    saw_rec   = 1'b0;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (bcd_valid === 1'b1) begin timed_out = 1'b0; break; end
    end
    saw_rec  = new_record;
    clear_hi = clr_on_done;
    tick();
    clear_hi = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; score = '0; game_end = 1'b0; clear_hi = 1'b0;
    tick(); tick();
    checks++;
    if (dut_vec() !== '0) begin
      failures++;
      $display("FAIL reset_state got=%h want=0", dut_vec());
    end
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if ({busy, bcd_valid, hundreds, tens, ones} !== '0) begin
        failures++;
        $display("FAIL idle_score0 cyc=%0d busy=%b valid=%b digits=%h%h%h want 0/0/000",
                 i, busy, bcd_valid, hundreds, tens, ones);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_convert();
    int n;
    bit seen;
    score = 8'd137; tick();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL busy_at_start got=%b want=1", busy); end
    seen = 0; n = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bcd_valid === 1'b1) begin seen = 1; n = i; break; end
    end
    checks++;
    if (!seen || n != W + 1) begin
      failures++; $display("FAIL latency_137 got=%0d want=%0d", n, W + 1);
    end
    checks++;
    if ({hundreds, tens, ones} !== 12'h137) begin
      failures++; $display("FAIL digits_137 got=%h%h%h want=137", hundreds, tens, ones);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || bcd_valid !== 1'b0) begin
      failures++; $display("FAIL busy_end_137 busy=%b valid=%b want 0/0", busy, bcd_valid);
    end
    $display("test_convert 137 -> %h%h%h latency=%0d", hundreds, tens, ones, n);
  endtask

  task automatic test_final_back_to_back();
    int pulses;
    bit seen;
    score = 8'd255; game_end = 1'b1; tick();
    tick(); score = 8'd9; tick(); score = 8'd42; tick(); score = 8'd99;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++; $display("FAIL final255_cycle got=%h want=%h", dut_vec(), model_vec());
      end
      if (bcd_valid === 1'b1) begin seen = 1; break; end
    end
    checks++;
    if (!seen || {hundreds, tens, ones} !== 12'h255 || new_record !== HI_EN) begin
      failures++;
      $display("FAIL final255 seen=%b digits=%h%h%h rec=%b want 255 rec=%b",
               seen, hundreds, tens, ones, new_record, HI_EN);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || hi_score !== (HI_EN ? W'(255) : W'(0))) begin
      failures++; $display("FAIL after255 busy=%b hi=%0d", busy, hi_score);
    end
    tick();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL followup_start busy=%b want=1", busy); end
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (bcd_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1 || {hundreds, tens, ones} !== 12'h099) begin
      failures++;
      $display("FAIL followup pulses=%0d digits=%h%h%h want 1 pulse 099", pulses, hundreds, tens, ones);
    end
    game_end = 1'b0; tick();
    $display("test_final_back_to_back followup=%h%h%h pulses=%0d", hundreds, tens, ones, pulses);
  endtask

`ifdef SCORE_HISCORE_EN
  task automatic test_hiscore();
    bit rec, to;
    clear_hi = 1'b1; tick(); clear_hi = 1'b0;
    checks++;
    if (hi_score !== '0) begin failures++; $display("FAIL clear_hi got=%0d want=0", hi_score); end
    run_final(8'd50, 1'b0, rec, to);
    checks++;
    if (to || rec !== 1'b1 || hi_score !== 8'd50) begin
      failures++; $display("FAIL hi50 to=%b rec=%b hi=%0d want rec=1 hi=50", to, rec, hi_score);
    end
    run_final(8'd50, 1'b0, rec, to);
    checks++;
    if (to || rec !== 1'b0 || hi_score !== 8'd50) begin
      failures++; $display("FAIL equal50 to=%b rec=%b hi=%0d want rec=0 hi=50", to, rec, hi_score);
    end
    run_final(8'd51, 1'b1, rec, to);
    checks++;
    if (to || rec !== 1'b1 || hi_score !== 8'd0) begin
      failures++; $display("FAIL rec51_clear to=%b rec=%b hi=%0d want rec=1 hi=0", to, rec, hi_score);
    end
    $display("test_hiscore final hi=%0d", hi_score);
  endtask
`else
  task automatic test_hiscore();
    bit rec, to;
    score = 8'd17; tick();
    repeat (12) tick();
    run_final(8'd99, 1'b0, rec, to);
    checks++;
    if (to || rec !== 1'b0 || hi_score !== '0 || {hundreds, tens, ones} !== 12'h099) begin
      failures++;
      $display("FAIL nohi99 to=%b rec=%b hi=%0d digits=%h%h%h want 099 rec=0 hi=0",
               to, rec, hi_score, hundreds, tens, ones);
    end
    $display("test_hiscore disabled digits=%h%h%h", hundreds, tens, ones);
  endtask
`endif

  task automatic test_reset_mid();
    bit seen;
    game_end = 1'b0;
    score = 8'd200; tick();
    repeat (4) tick();
    rst = 1'b1; tick();
    checks++;
    if (dut_vec() !== '0) begin failures++; $display("FAIL reset_mid got=%h want=0", dut_vec()); end
    rst = 1'b0; tick();
    checks++;
    if (busy !== 1'b1 || bcd_valid !== 1'b0) begin
      failures++; $display("FAIL restart200 busy=%b valid=%b want 1/0", busy, bcd_valid);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bcd_valid === 1'b1) begin seen = 1; break; end
    end
    checks++;
    if (!seen || {hundreds, tens, ones} !== 12'h200) begin
      failures++; $display("FAIL conv200 seen=%b digits=%h%h%h want 200", seen, hundreds, tens, ones);
    end
    repeat (3) tick();
    $display("test_reset_mid digits=%h%h%h", hundreds, tens, ones);
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0)  score    = W'($urandom_range(255));
      if ($urandom_range(15) == 0) game_end = ~game_end;
      clear_hi = ($urandom_range(39) == 0);
      rst      = ($urandom_range(299) == 0);
      tick();
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++; errs++;
        if (errs <= 10) $display("FAIL random cyc=%0d got=%h want=%h", i, dut_vec(), model_vec());
      end
    end
    rst = 1'b0; clear_hi = 1'b0;
    $display("test_random cycles=3000 errors=%0d", errs);
  endtask

  initial begin
    test_reset();
    test_convert();
    test_final_back_to_back();
    test_hiscore();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
